// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin arbiter and big-endian byte sequencer for a byte-wide data memory.
// Optional misaligned-access rejection when DMEM_ALIGN_CHK_EN is defined.
module dmem_access_ctrl #(
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          WE0,
    input  logic [31:0]   A0,
    input  logic [31:0]   WD0,
    output logic          gnt0,
    output logic          done0,
    output logic [31:0]   RD0,
    output logic          err0,
    input  logic          req1,
    input  logic          WE1,
    input  logic [31:0]   A1,
    input  logic [31:0]   WD1,
    output logic          gnt1,
    output logic          done1,
    output logic [31:0]   RD1,
    output logic          err1,
    output logic [AW-1:0] mem_A,
    output logic [7:0]    mem_WD,
    output logic          mem_WE,
    input  logic [7:0]    mem_RD
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t        state, state_nx;
    logic          rr_last;
    logic          owner;
    logic          we_q;
    logic [AW-1:0] base;
    logic [31:0]   wd_q;
    logic [23:0]   rbuf;
    logic [1:0]    beat;
    logic          any_req;
    logic          sel;
    logic [1:0]    sel_lsb;

`ifdef DMEM_ALIGN_CHK_EN
    logic mis_q;
`endif

    assign any_req = req0 | req1;
    assign sel     = (req0 & req1) ? ~rr_last : req1;
    assign sel_lsb = sel ? A1[1:0] : A0[1:0];

    always_comb begin
        state_nx = state;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        err0     = 1'b0;
        err1     = 1'b0;
        mem_WE   = 1'b0;
        mem_A    = '0;
        mem_WD   = 8'h00;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt0     = ~sel;
                    gnt1     = sel;
                    state_nx = XFER;
`ifdef DMEM_ALIGN_CHK_EN
                    if (sel_lsb != 2'b00) state_nx = RESP;
`endif
                end
            end
            XFER: begin
                mem_A  = base + AW'(beat);
                // Gate the strobe with rst so an aborted store writes no further byte.
                mem_WE = we_q & ~rst;
                case (beat)
                    2'd0:    mem_WD = wd_q[31:24];
                    2'd1:    mem_WD = wd_q[23:16];
                    2'd2:    mem_WD = wd_q[15:8];
                    default: mem_WD = wd_q[7:0];
                endcase
                if (beat == 2'd3) state_nx = RESP;
            end
            RESP: begin
                done0    = ~owner;
                done1    = owner;
`ifdef DMEM_ALIGN_CHK_EN
                err0     = mis_q & ~owner;
                err1     = mis_q & owner;
`endif
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_last <= 1'b1;
            owner   <= 1'b0;
            we_q    <= 1'b0;
            base    <= '0;
            wd_q    <= 32'h0;
            rbuf    <= 24'h0;
            beat    <= 2'd0;
            RD0     <= 32'h0;
            RD1     <= 32'h0;
`ifdef DMEM_ALIGN_CHK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner   <= sel;
                        rr_last <= sel;
                        we_q    <= sel ? WE1 : WE0;
                        base    <= sel ? A1[AW-1:0] : A0[AW-1:0];
                        wd_q    <= sel ? WD1 : WD0;
                        beat    <= 2'd0;
`ifdef DMEM_ALIGN_CHK_EN
                        mis_q   <= (sel_lsb != 2'b00);
`endif
                    end
                end
                XFER: begin
                    beat <= beat + 2'd1;
                    if (!we_q) begin
                        // Last byte goes straight into RDn so it is valid during done.
                        case (beat)
                            2'd0: rbuf[23:16] <= mem_RD;
                            2'd1: rbuf[15:8]  <= mem_RD;
                            2'd2: rbuf[7:0]   <= mem_RD;
                            default: begin
                                if (owner) RD1 <= {rbuf, mem_RD};
                                else       RD0 <= {rbuf, mem_RD};
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef DMEM_ALIGN_CHK_EN
    logic unused_lsb;
    assign unused_lsb = &{1'b0, sel_lsb};
`endif

    generate
        if (AW < 32) begin : g_hi
            logic unused_hi;
            assign unused_hi = &{1'b0, A0[31:AW], A1[31:AW]};
        end
    endgenerate

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: vector table plus hand-written contention,
// reset-abort and (when DMEM_ALIGN_CHK_EN is defined) misalignment sequences.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, WE0, gnt0, done0, err0;
    logic [31:0] A0, WD0, RD0;
    logic        req1, WE1, gnt1, done1, err1;
    logic [31:0] A1, WD1, RD1;
    logic [7:0]  mem_A, mem_WD, mem_RD;
    logic        mem_WE;
    logic        mem_clr;

    int n_chk  = 0;
    int n_fail = 0;

    dmem_access_ctrl #(.AW(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .WE0(WE0), .A0(A0), .WD0(WD0),
        .gnt0(gnt0), .done0(done0), .RD0(RD0), .err0(err0),
        .req1(req1), .WE1(WE1), .A1(A1), .WD1(WD1),
        .gnt1(gnt1), .done1(done1), .RD1(RD1), .err1(err1),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
    );

    always #5 clk = ~clk;

    // Byte memory model: combinational read, write on the clock edge.
    logic [7:0] mem [0:255];
    assign mem_RD = mem[mem_A];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hAA;
        end else if (mem_WE) begin
            mem[mem_A] <= mem_WD;
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic r, input logic we,
                         input logic [31:0] a, input logic [31:0] wd);
        if (!p) begin
            req0 = r; WE0 = we; A0 = a; WD0 = wd;
        end else begin
            req1 = r; WE1 = we; A1 = a; WD1 = wd;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic do_xfer(input vec_t v);
        bit got;
        int lat;
        drive(v.port, 1'b1, v.we, v.addr, v.wd);
        #1;
        chk("grant", 32'({gnt1, gnt0}), v.port ? 32'h2 : 32'h1);
        step();
        // Scramble the inputs after the grant edge; the latched copies must be used.
        drive(v.port, 1'b0, ~v.we, v.addr ^ 32'h0000_0055, ~v.wd);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            if (c > 1) step();
            if (v.port ? done1 : done0) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk("done_latency", 32'(lat), 32'd5);
        if (got) begin
            chk("read_data", v.port ? RD1 : RD0, v.exp_rd);
            chk("err_clear", 32'(v.port ? err1 : err0), 32'd0);
            chk("other_done", 32'(v.port ? done0 : done1), 32'd0);
        end
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        bit exp_g;
        bit last_owner;
        int ng;
        bit got;
        int lat;

        rst = 1'b1; mem_clr = 1'b1;
        req0 = 0; WE0 = 0; A0 = 0; WD0 = 0;
        req1 = 0; WE1 = 0; A1 = 0; WD1 = 0;
        step();
        mem_clr = 1'b0;
        do_reset();
        #1;

        chk("rst_gnt",  32'({gnt1, gnt0}), 32'h0);
        chk("rst_done", 32'({done1, done0}), 32'h0);
        chk("rst_err",  32'({err1, err0}), 32'h0);
        chk("rst_rd0",  RD0, 32'h0);
        chk("rst_rd1",  RD1, 32'h0);
        chk("rst_mem",  32'({mem_WE, mem_A, mem_WD}), 32'h0);

        vecs.push_back('{1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF});
        vecs.push_back('{1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D});
        vecs.push_back('{1'b0, 1'b0, 32'h40, 32'h0,        32'hCAFEF00D});
        vecs.push_back('{1'b1, 1'b1, 32'h80, 32'h01020304, 32'hCAFEF00D});
        vecs.push_back('{1'b0, 1'b1, 32'h14, 32'h55667788, 32'hCAFEF00D});
`ifndef DMEM_ALIGN_CHK_EN
        vecs.push_back('{1'b1, 1'b0, 32'h12, 32'h0,        32'hBEEF5566});
        vecs.push_back('{1'b1, 1'b1, 32'hFE, 32'h11223344, 32'hBEEF5566});
        vecs.push_back('{1'b0, 1'b0, 32'hFE, 32'h0,        32'h11223344});
`endif
        vecs.push_back('{1'b0, 1'b0, 32'h80, 32'h0,        32'h01020304});

        foreach (vecs[i]) do_xfer(vecs[i]);

        chk("mem_10", 32'(mem[8'h10]), 32'hDE);
        chk("mem_11", 32'(mem[8'h11]), 32'hAD);
        chk("mem_12", 32'(mem[8'h12]), 32'hBE);
        chk("mem_13", 32'(mem[8'h13]), 32'hEF);
`ifndef DMEM_ALIGN_CHK_EN
        chk("wrap_fe", 32'(mem[8'hFE]), 32'h11);
        chk("wrap_ff", 32'(mem[8'hFF]), 32'h22);
        chk("wrap_00", 32'(mem[8'h00]), 32'h33);
        chk("wrap_01", 32'(mem[8'h01]), 32'h44);
`else
        // Misaligned load on port 1: error response, no beats, RD1 untouched.
        drive(1'b1, 1'b1, 1'b0, 32'h21, 32'h0);
        #1;
        chk("mis_gnt1", 32'({gnt1, gnt0}), 32'h2);
        chk("mis_we0", 32'(mem_WE), 32'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("mis_done1", 32'(done1), 32'd1);
        chk("mis_err1", 32'(err1), 32'd1);
        chk("mis_we1", 32'(mem_WE), 32'd0);
        chk("mis_rd1", RD1, 32'hCAFEF00D);
        step();
        chk("mis_idle", 32'({done1, err1, mem_WE}), 32'h0);
`endif

        // Contention: both ports hold load requests; grants must alternate from port 0.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        ng = 0;
        last_owner = 1'b0;
        for (int i = 0; i < 26; i++) begin
            chk("no_gnt_overlap", 32'(gnt0 & gnt1), 32'd0);
            chk("no_done_overlap", 32'(done0 & done1), 32'd0);
            if (gnt0 | gnt1) begin
                exp_g = ng[0];
                chk("rr_order", 32'(gnt1), 32'(exp_g));
                last_owner = gnt1;
                ng++;
            end
            if (done0 | done1) begin
                chk("cont_owner", 32'(done1), 32'(last_owner));
                chk("cont_rd", done1 ? RD1 : RD0, done1 ? 32'hCAFEF00D : 32'hDEADBEEF);
            end
            step();
        end
        chk("cont_grants", 32'(ng), 32'd5);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) step();

        // Reset during beat 2 of a port-1 store: beats 0-1 land, 2-3 do not.
        do_reset();
        drive(1'b1, 1'b1, 1'b1, 32'h60, 32'h11223344);
        #1;
        chk("abort_gnt1", 32'({gnt1, gnt0}), 32'h2);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_we", 32'(mem_WE), 32'd0);
        chk("abort_done", 32'({done1, done0}), 32'h0);
        step();
        chk("abort_idle", 32'({done1, done0, mem_WE}), 32'h0);
        chk("abort_b0", 32'(mem[8'h60]), 32'h11);
        chk("abort_b1", 32'(mem[8'h61]), 32'h22);
        chk("abort_b2", 32'(mem[8'h62]), 32'hAA);
        chk("abort_b3", 32'(mem[8'h63]), 32'hAA);

        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        chk("post_abort_gnt", 32'({gnt1, gnt0}), 32'h1);
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && !got; c++) begin
            if (c > 1) step();
            if (done0) begin
                got = 1'b1;
                lat = c;
            end
        end
        chk("post_abort_lat", 32'(lat), 32'd5);
        chk("post_abort_rd", RD0, 32'hDEADBEEF);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Two-requester arbiter and byte sequencer in front of the byte-wide data memory.
- Each requester issues 32-bit word loads and stores. The block grants one requester at a time using round-robin.
- Each word is moved as 4 consecutive byte beats on the memory port, big-endian: the byte at address A carries bits 31:24.
- Port 0 serves the load/store stage; port 1 serves the loader/debug path.

Parameters:
- AW, 8, byte address width of the memory port. Only A[AW-1:0] is used; upper address bits are ignored.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req0  in  1  port 0 request; held until gnt0
- WE0  in  1  port 0 write enable (1 = store, 0 = load)
- A0  in  32  port 0 byte address of the word
- WD0  in  32  port 0 store data
- gnt0  out  1  port 0 request accepted (combinational, IDLE only)
- done0  out  1  port 0 one-cycle completion pulse
- RD0  out  32  port 0 load data; valid at done0, held afterwards
- err0  out  1  port 0 misaligned-access flag; valid with done0
- req1, WE1, A1, WD1, gnt1, done1, RD1, err1: same as port 0, for port 1
- mem_A  out  AW  byte address to memory
- mem_WD  out  8  byte write data
- mem_WE  out  1  byte write strobe; memory writes on the clk edge
- mem_RD  in  8  byte read data; memory read is combinational from mem_A

Behaviour:
- Clock and reset:
  - One clock.
  - rst is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values:
  - State = IDLE, rr_last = 1 (so port 0 wins first).
  - gnt*, done*, err* = 0; RD0 = RD1 = 0.
  - mem_WE = 0, mem_A = 0, mem_WD = 0.
- States: IDLE, XFER, RESP.
- IDLE:
  - Select a port:
    - Only one reqN high: that port is selected.
    - Both high: the port != rr_last is selected.
  - gntN = 1 combinationally for the selected port.
  - On the clk edge, latch port id, WE, A[AW-1:0] and WD, and set beat = 0.
  - Update rr_last = selected port, then go to XFER.
  - No request: stay in IDLE; mem_WE = 0.
- XFER (beat counter 0..3):
  - mem_A = base + beat, computed mod 2^AW (wrap-around is legal).
  - Store:
    - mem_WE = 1.
    - mem_WD = WD[31-8*beat -: 8].
  - Load:
    - mem_WE = 0.
    - Capture mem_RD into buffer lane [31-8*beat -: 8] on the edge.
  - beat == 3: go to RESP; otherwise beat increments.
- RESP:
  - doneN = 1 for exactly one cycle for the owning port.
  - Load: RDN = buffer, held until that port's next load completes. Stores leave RDN unchanged.
  - Then go to IDLE. No new grant is given in RESP cycles.
- Latency:
  - Grant in cycle 0, beats in cycles 1-4, done in cycle 5.
  - Throughput is one word per 6 cycles.
- Requester rules:
  - A requester may drop reqN or change its inputs after the gnt edge; the latched copies are used.
  - reqN held across a done pulse is treated as a new request.
  - The non-owning port's req is ignored until IDLE.
- Simultaneous events:
  - Both requests arriving in the same IDLE cycle follow round-robin.
  - A port repeatedly requesting cannot starve the other: they alternate under contention.
- Reset mid-operation:
  - Abort immediately and return to IDLE.
  - mem_WE = 0 from the next cycle. No done pulse is generated.
  - Partial bytes already written remain in memory.
- mem_A and mem_WD are don't-care while mem_WE = 0 in IDLE/RESP, but are driven (no X).

Optional Feature:
- Macro: DMEM_ALIGN_CHK_EN.
- Defined:
  - A grant with A[1:0] != 2'b00 skips XFER and goes directly to RESP.
  - doneN and errN = 1 together in the cycle after the grant.
  - No memory beats are issued; mem_WE stays 0.
  - RDN is unchanged.
- Not defined:
  - errN is tied 0.
  - Any byte address is accepted; beats run from A with mod 2^AW wrap.

Test Plan:
- Store then load, port 0: A0=0x10, WD0=0xDEADBEEF, WE0=1, then a load from 0x10 -> mem bytes at 0x10..0x13 = DE, AD, BE, EF; done0 in cycle 5 after each grant; RD0 = 0xDEADBEEF.
- Contention: req0 and req1 held continuously, both loads -> grants alternate 0, 1, 0, 1 starting with port 0; each done matches its owner; no done overlap.
- Wrap, AW=8, macro off: store 0x11223344 at A=0xFE -> bytes land at 0xFE, 0xFF, 0x00, 0x01 = 11, 22, 33, 44.
- Misaligned, macro on: load A1=0x21 -> gnt1, then done1 = err1 = 1 in the next cycle; mem_WE never asserted; RD1 unchanged.
- Reset mid-store: assert rst during beat 2 of a store -> next cycle state is IDLE, mem_WE = 0, no done; bytes for beats 0-1 are written, beats 2-3 are not; a following request is granted normally, port 0 first.
- Input change after grant: change A0/WD0 in the cycle after gnt0 -> the transfer uses the latched values.
